// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and timing constants for the tank controller
package tank_pkg;

    // Timer arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2,
        HOLD   = 2'd3
    } timer_arb_state_t;

    // clk cycles per 1 ms tick at 50 MHz.
    localparam int TICK_DIV_1MS = 50000;

    // Tank FSM durations, in ms ticks.
    localparam int T_DETECT_MS = 5000;
    localparam int T_HIT_MS    = 5000;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - parameterised prescaler producing a one-cycle tick
//
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   clear     forces the prescaler back to 0 (wins over enable)
//   enable    advances the prescaler by one each cycle
//   tick      high during the enabled cycle in which the prescaler is DIV-1
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin shared countdown timer for the tank FSMs
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   req          per-requester request, held for the whole use of the timer
//   load_value   per-requester duration in ticks, slice i at [i*CNT_W +: CNT_W]
//   gnt          one-hot owner, zero when unowned
//   busy         timer owned
//   timer_value  remaining ticks of the owner, zero when unowned
//   expired      one-cycle pulse to the owner when its count reaches zero
module timer_arbiter
    import tank_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = TICK_DIV_1MS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   load_value,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [CNT_W-1:0]         timer_value,
    output logic [N_REQ-1:0]         expired
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    timer_arb_state_t state, state_next;

    logic [OW-1:0]    owner;
    logic [OW-1:0]    rr_ptr;
    logic [OW-1:0]    pick;
    logic             pick_valid;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] load_sel;
    logic             owner_req;
    logic             tick;
    logic [N_REQ-1:0] owner_onehot;

    // Round-robin search starting just after ptr. Candidates are visited
    // farthest-first so the nearest requester after ptr is the last write;
    // ptr itself is the lowest-priority candidate.
    function automatic logic [OW:0] rr_select(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    ptr);
        logic [OW:0]   res;
        logic [OW-1:0] sel;
        int            idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = OW'(idx);
            if (r[sel]) begin
                res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    assign {pick_valid, pick} = rr_select(req, rr_ptr);
    assign load_sel           = load_value[pick*CNT_W +: CNT_W];
    assign owner_req          = req[owner];
    assign owner_onehot       = {{(N_REQ-1){1'b0}}, 1'b1} << owner;

    // Prescaler only runs while counting; held clear otherwise so each
    // grant starts from a full tick period.
    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != RUN),
        .enable (state == RUN),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving RUN on the tick that takes count from 1 to 0 lines the
    // expired pulse up with timer_value reaching 0 at the outputs.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    state_next = EXPIRE;
                end else if (tick && (count == CNT_W'(1))) begin
                    state_next = EXPIRE;
                end
            end
            EXPIRE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= '0;
            rr_ptr <= OW'(N_REQ - 1);
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner  <= pick;
                        rr_ptr <= pick;
                        count  <= load_sel;
                    end
                end
                RUN: begin
                    if (!owner_req) begin
                        count <= '0;
                    end else if (tick && (count != '0)) begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered copies decoded from the state/owner/count
    // registers, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt         <= '0;
            busy        <= 1'b0;
            timer_value <= '0;
            expired     <= '0;
        end else begin
            gnt         <= (state != IDLE)   ? owner_onehot : '0;
            busy        <= (state != IDLE);
            timer_value <= (state != IDLE)   ? count        : '0;
            expired     <= (state == EXPIRE) ? owner_onehot : '0;
        end
    end

endmodule
